motor_encoder_reader: RTL and testbench



---
 rtl/motor_encoder_reader_pkg.sv | 11 +
 rtl/enc_input_filter.sv | 29 ++
 rtl/motor_encoder_reader.sv | 59 +++++
 tb/tb_motor_encoder_reader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/motor_encoder_reader_pkg.sv
// motor_encoder_reader_pkg: shared direction constants, encoder state encodings and quadrature helper
package motor_encoder_reader_pkg;
  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;
  localparam int CLK_HZ = 100_000_000;
  typedef enum logic [1:0] {ST_00 = 2'b00, ST_10 = 2'b10, ST_11 = 2'b11, ST_01 = 2'b01} enc_state_e;
  // Maps the Gray-coded {A,B} state onto a 0..3 phase so forward is +1 and reverse is -1 mod 4
  function automatic logic [1:0] quad_phase(input enc_state_e s);
    return {s[0], s[1] ^ s[0]};
  endfunction
endpackage

// File: rtl/enc_input_filter.sv
// enc_input_filter: 2-FF synchroniser plus stability-count glitch filter for one encoder channel
module enc_input_filter #(
  parameter int GLITCH_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);
  localparam int CW = $clog2(GLITCH_CYCLES + 1);
  logic sync1, sync2;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      dout  <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (sync2 == dout) cnt <= '0;
      else if (cnt == CW'(GLITCH_CYCLES - 1)) begin
        dout <= sync2;
        cnt  <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/motor_encoder_reader.sv
// motor_encoder_reader: filtered 4x quadrature decoder with wrapping position and windowed speed
module motor_encoder_reader
  import motor_encoder_reader_pkg::*;
#(
  parameter int GLITCH_CYCLES = 4,
  parameter int WINDOW_CYCLES = 10_000_000,
  parameter int POS_W = 16,
  parameter int SPD_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ENC_A,
  input  logic             ENC_B,
  output logic [POS_W-1:0] position,
  output logic             direction,
  output logic [SPD_W-1:0] speed,
  output logic             speed_valid,
  output logic             enc_error
);
  localparam int WW = $clog2(WINDOW_CYCLES);
  localparam logic [SPD_W-1:0] SPD_MAX = '1;
  logic filt_a, filt_b, fwd, rev, bad, terminal;
  logic [1:0] step;
  enc_state_e prev, curr;
  logic [WW-1:0] win_cnt;
  logic [SPD_W-1:0] edge_cnt, edge_next;
  enc_input_filter #(.GLITCH_CYCLES(GLITCH_CYCLES)) u_filt_a (.clk(clk), .reset(reset), .din(ENC_A), .dout(filt_a));
  enc_input_filter #(.GLITCH_CYCLES(GLITCH_CYCLES)) u_filt_b (.clk(clk), .reset(reset), .din(ENC_B), .dout(filt_b));
  always_comb begin
    curr      = enc_state_e'({filt_a, filt_b});
    step      = quad_phase(curr) - quad_phase(prev);
    fwd       = step == 2'd1;
    rev       = step == 2'd3;
    bad       = step == 2'd2;
    terminal  = win_cnt == WW'(WINDOW_CYCLES - 1);
    edge_next = (edge_cnt == SPD_MAX) ? edge_cnt : edge_cnt + SPD_W'(fwd | rev);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      prev        <= ST_00;
      position    <= '0;
      direction   <= DIR_FWD;
      speed       <= '0;
      speed_valid <= 1'b0;
      enc_error   <= 1'b0;
      win_cnt     <= '0;
      edge_cnt    <= '0;
    end else begin
      prev        <= curr;
      position    <= fwd ? position + POS_W'(1) : rev ? position - POS_W'(1) : position;
      direction   <= fwd ? DIR_FWD : rev ? DIR_REV : direction;
      enc_error   <= enc_error | bad;
      win_cnt     <= terminal ? '0 : win_cnt + 1'b1;
      edge_cnt    <= terminal ? '0 : edge_next;
      speed       <= terminal ? edge_next : speed;
      speed_valid <= terminal;
    end
  end
endmodule

// File: tb/tb_motor_encoder_reader.sv
// tb_motor_encoder_reader: directed stimulus with a per-cycle behavioural model and literal spot checks
module tb_motor_encoder_reader;
  logic clk = 1'b0, reset = 1'b1;
  logic a0 = 1'b0, b0 = 1'b0, a1 = 1'b0, b1 = 1'b0;
  logic [15:0] pos0, pos1;
  logic [11:0] spd0, spd1;
  logic dir0, dir1, sv0, sv1, err0, err1;
  int errors = 0, checks = 0, cyc = 0, ph0 = 0, ph1 = 0;

  always #5 clk = ~clk;

  motor_encoder_reader #(.GLITCH_CYCLES(4), .WINDOW_CYCLES(1000), .POS_W(16), .SPD_W(12)) dut0 (
    .clk(clk), .reset(reset), .ENC_A(a0), .ENC_B(b0), .position(pos0), .direction(dir0),
    .speed(spd0), .speed_valid(sv0), .enc_error(err0));
  motor_encoder_reader #(.GLITCH_CYCLES(1), .WINDOW_CYCLES(6000), .POS_W(16), .SPD_W(12)) dut1 (
    .clk(clk), .reset(reset), .ENC_A(a1), .ENC_B(b1), .position(pos1), .direction(dir1),
    .speed(spd1), .speed_valid(sv1), .enc_error(err1));

  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  // Behavioural model: one slot per DUT instance
  int mG[2] = '{4, 1};
  int mW[2] = '{1000, 6000};
  bit ms1a[2], ms2a[2], ms1b[2], ms2b[2], mfa[2], mfb[2], mpa[2], mpb[2];
  bit ha[2][4], hb[2][4];
  int mpos[2], mk[2], medges[2], mspd[2];
  bit mdir[2], msv[2], merr[2];
  bit model_live = 1'b0;

  function automatic int phase(bit x, bit y);
    case ({x, y})
      2'b00: return 0;
      2'b10: return 1;
      2'b11: return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] ab_of(int p);
    case (p)
      0: return 2'b00;
      1: return 2'b10;
      2: return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  task automatic model_step(input int i, input bit r, input bit a, input bit b);
    int d;
    bit ok_a, ok_b;
    if (r) begin
      ms1a[i] = 0; ms2a[i] = 0; ms1b[i] = 0; ms2b[i] = 0;
      mfa[i] = 0; mfb[i] = 0; mpa[i] = 0; mpb[i] = 0;
      for (int j = 0; j < 4; j++) begin ha[i][j] = 0; hb[i][j] = 0; end
      mpos[i] = 0; mk[i] = 0; medges[i] = 0; mspd[i] = 0;
      mdir[i] = 1; msv[i] = 0; merr[i] = 0;
    end else begin
      mk[i]++;
      d = (phase(mfa[i], mfb[i]) - phase(mpa[i], mpb[i]) + 4) % 4;
      if (d == 1) begin mpos[i] = (mpos[i] + 1) % 65536; mdir[i] = 1; medges[i]++; end
      else if (d == 3) begin mpos[i] = (mpos[i] + 65535) % 65536; mdir[i] = 0; medges[i]++; end
      else if (d == 2) merr[i] = 1;
      msv[i] = (mk[i] % mW[i]) == 0;
      if (msv[i]) begin
        mspd[i] = medges[i] > 4095 ? 4095 : medges[i];
        medges[i] = 0;
      end
      mpa[i] = mfa[i];
      mpb[i] = mfb[i];
      for (int j = 3; j > 0; j--) begin ha[i][j] = ha[i][j-1]; hb[i][j] = hb[i][j-1]; end
      ha[i][0] = ms2a[i];
      hb[i][0] = ms2b[i];
      ok_a = 1;
      ok_b = 1;
      for (int j = 0; j < mG[i]; j++) begin
        if (ha[i][j] == mfa[i]) ok_a = 0;
        if (hb[i][j] == mfb[i]) ok_b = 0;
      end
      if (ok_a) mfa[i] = ha[i][0];
      if (ok_b) mfb[i] = hb[i][0];
      ms2a[i] = ms1a[i]; ms1a[i] = a;
      ms2b[i] = ms1b[i]; ms1b[i] = b;
    end
  endtask

  always @(posedge clk) begin
    model_step(0, reset, a0, b0);
    model_step(1, reset, a1, b1);
    model_live = 1'b1;
  end

  task automatic cmp(input int i, input logic [30:0] got);
    logic [30:0] exp;
    exp = {16'(mpos[i]), mdir[i], 12'(mspd[i]), msv[i], merr[i]};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL model_dut%0d cyc=%0d got pos=%h dir=%b spd=%0d sv=%b err=%b expected pos=%h dir=%b spd=%0d sv=%b err=%b",
               i, cyc, got[30:15], got[14], got[13:2], got[1], got[0], exp[30:15], exp[14], exp[13:2], exp[1], exp[0]);
    end
  endtask

  always @(negedge clk) if (model_live) begin
    cmp(0, {pos0, dir0, spd0, sv0, err0});
    cmp(1, {pos1, dir1, spd1, sv1, err1});
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic move0(input int d);
    ph0 = (ph0 + d + 4) % 4;
    {a0, b0} = ab_of(ph0);
  endtask

  task automatic move1(input int d);
    ph1 = (ph1 + d + 4) % 4;
    {a1, b1} = ab_of(ph1);
  endtask

  initial begin
    repeat (3) begin @(negedge clk); a0 = ~a0; b0 = ~b0; end
    @(negedge clk);
    check("reset_pos", 32'(pos0), 0);
    check("reset_dir", 32'(dir0), 1);
    check("reset_spd", 32'(spd0), 0);
    check("reset_sv", 32'(sv0), 0);
    check("reset_err", 32'(err0), 0);
    reset = 1'b0; a0 = 1'b0; b0 = 1'b0;
    cycles(1);
    move0(1);
    cycles(6);
    check("latency_pos_before", 32'(pos0), 0);
    cycles(1);
    check("latency_pos_after", 32'(pos0), 1);
    check("latency_dir", 32'(dir0), 1);
    repeat (7) begin move0(1); cycles(20); end
    check("fwd8_pos", 32'(pos0), 8);
    check("fwd8_dir", 32'(dir0), 1);
    check("fwd8_err", 32'(err0), 0);
    repeat (3) begin move0(-1); cycles(20); end
    check("rev3_pos", 32'(pos0), 5);
    check("rev3_dir", 32'(dir0), 0);
    a0 = 1'b0; cycles(3); a0 = 1'b1; cycles(20);
    check("glitch3_pos", 32'(pos0), 5);
    b0 = 1'b1; cycles(4); b0 = 1'b0; cycles(3);
    check("pulse4_pos", 32'(pos0), 6);
    check("pulse4_dir", 32'(dir0), 1);
    cycles(20);
    check("pulse4_back", 32'(pos0), 5);
    move0(-1); cycles(20);
    check("pre_illegal_pos", 32'(pos0), 4);
    a0 = 1'b1; b0 = 1'b1; ph0 = 2; cycles(20);
    check("illegal_err", 32'(err0), 1);
    check("illegal_pos", 32'(pos0), 4);
    move0(1); cycles(20);
    check("post_illegal_pos", 32'(pos0), 5);
    check("err_sticky", 32'(err0), 1);
    reset = 1'b1; a0 = 1'b0; b0 = 1'b0; ph0 = 0;
    cycles(2);
    check("reset2_err", 32'(err0), 0);
    check("reset2_pos", 32'(pos0), 0);
    reset = 1'b0;
    repeat (50) begin move0(1); cycles(10); end
    wait_until(999);
    check("win1_sv_early", 32'(sv0), 0);
    wait_until(1000);
    check("win1_sv", 32'(sv0), 1);
    check("win1_spd", 32'(spd0), 50);
    wait_until(1001);
    check("win1_sv_single", 32'(sv0), 0);
    wait_until(2000);
    check("win2_sv", 32'(sv0), 1);
    check("win2_spd", 32'(spd0), 0);
    wait_until(2993);
    move0(1);
    wait_until(2999);
    check("term_pos_before", 32'(pos0), 50);
    wait_until(3000);
    check("term_pos", 32'(pos0), 51);
    check("term_spd", 32'(spd0), 1);
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    cycles(2);
    move1(-1); cycles(4);
    check("wrap_ffff", 32'(pos1), 32'h0000_FFFF);
    check("wrap_ffff_dir", 32'(dir1), 0);
    move1(1); cycles(4);
    check("wrap_zero", 32'(pos1), 0);
    repeat (32767) begin move1(1); cycles(1); end
    cycles(4);
    check("pos_7fff", 32'(pos1), 32'h0000_7FFF);
    check("spd_sat", 32'(spd1), 4095);
    move1(1); cycles(4);
    check("wrap_8000", 32'(pos1), 32'h0000_8000);
    check("wrap_8000_dir", 32'(dir1), 1);
    check("dut1_err", 32'(err1), 0);
    cycles(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
